// File: rtl/secuenciador_bandas_filtro.sv
// Band sequencer for the time-multiplexed three-band biquad: walks altas, medias
// and bajas in turn, pulses each band's state enable and captures each band's output.
module secuenciador_bandas_filtro #(
    parameter int Width  = 22,
    parameter int SETTLE = 2
) (
    input  logic                    clk150kHz,
    input  logic                    reset,
    input  logic                    sample_valid,
    input  logic signed [Width-1:0] sample_in,
    input  logic                    clear_overrun,
    input  logic signed [Width-1:0] y_filtro,
    output logic signed [Width-1:0] uk,
    output logic        [1:0]       sel_muxes,
    output logic                    enable1,
    output logic                    enable2,
    output logic                    enable3,
    output logic signed [Width-1:0] y_altas,
    output logic signed [Width-1:0] y_medias,
    output logic signed [Width-1:0] y_bajas,
    output logic                    bands_valid,
    output logic                    busy,
    output logic                    overrun,
    output logic        [1:0]       state_dbg
);

    // Handshake: sample_valid is a one-cycle strobe taken only in st_idle; a strobe
    // seen while busy is dropped and recorded in overrun. bands_valid is a one-cycle
    // strobe with no back-pressure; the band registers stay valid until the next capture.

    typedef enum logic [1:0] {
        st_idle    = 2'd0,
        st_settle  = 2'd1,
        st_capture = 2'd2,
        st_done    = 2'd3
    } estado_t;

    localparam logic [3:0] cnt_last = 4'(SETTLE - 1);

    estado_t     state;
    estado_t     state_next;
    logic [1:0]  band;
    logic [3:0]  cnt;
    logic        drop;

    assign drop = sample_valid && (state != st_idle);

    always_ff @(posedge clk150kHz or negedge reset) begin
        if (!reset) begin
            state <= st_idle;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            st_idle: begin
                if (sample_valid) begin
                    state_next = st_settle;
                end
            end
            st_settle: begin
                if (cnt == cnt_last) begin
                    state_next = st_capture;
                end
            end
            st_capture: begin
                if (band == 2'd2) begin
                    state_next = st_done;
                end else begin
                    state_next = st_settle;
                end
            end
            st_done: begin
                state_next = st_idle;
            end
            default: begin
                state_next = st_idle;
            end
        endcase
    end

    // Enables and strobes decode registered state only, so no input reaches an output.
    always_comb begin
        enable1     = (state == st_capture) && (band == 2'd0);
        enable2     = (state == st_capture) && (band == 2'd1);
        enable3     = (state == st_capture) && (band == 2'd2);
        bands_valid = (state == st_done);
        busy        = (state != st_idle);
        state_dbg   = state;
    end

    always_ff @(posedge clk150kHz or negedge reset) begin
        if (!reset) begin
            band      <= 2'd0;
            cnt       <= 4'd0;
            sel_muxes <= 2'd0;
            uk        <= '0;
            y_altas   <= '0;
            y_medias  <= '0;
            y_bajas   <= '0;
        end else begin
            case (state)
                st_idle: begin
                    if (sample_valid) begin
                        uk        <= sample_in;
                        sel_muxes <= 2'd0;
                        band      <= 2'd0;
                        cnt       <= 4'd0;
                    end
                end
                st_settle: begin
                    cnt <= cnt + 4'd1;
                end
                st_capture: begin
                    // The filter's delay registers update on this same edge.
                    case (band)
                        2'd0:    y_altas  <= y_filtro;
                        2'd1:    y_medias <= y_filtro;
                        2'd2:    y_bajas  <= y_filtro;
                        default: ;
                    endcase
                    if (band != 2'd2) begin
                        band      <= band + 2'd1;
                        sel_muxes <= band + 2'd1;
                        cnt       <= 4'd0;
                    end
                end
                st_done: begin
                    sel_muxes <= 2'd0;
                end
                default: ;
            endcase
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk150kHz or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_secuenciador_bandas_filtro.sv
// Bench for the band sequencer: directed samples, a filter model keyed on sel_muxes,
// and a scoreboard that checks the band registers on each bands_valid.
module tb_secuenciador_bandas_filtro;
    localparam int W = 22;
    localparam int S = 2;
    localparam int LAST = 3 * (S + 1);

    logic                clk = 1'b0;
    logic                reset;
    logic                sample_valid;
    logic signed [W-1:0] sample_in;
    logic                clear_overrun;
    logic signed [W-1:0] y_filtro;
    logic signed [W-1:0] uk;
    logic [1:0]          sel_muxes;
    logic                enable1, enable2, enable3;
    logic signed [W-1:0] y_altas, y_medias, y_bajas;
    logic                bands_valid, busy, overrun;
    logic [1:0]          state_dbg;

    logic signed [W-1:0] y_tab [3];
    logic [3*W-1:0]      exp_q [$];
    logic [3*W-1:0]      mon_e;
    int                  bv_cyc [$];
    int                  n_checks = 0;
    int                  n_pass = 0;
    int                  cyc = 0;
    logic                exp_ovr, drv_drop, drv_clr;

    secuenciador_bandas_filtro #(.Width(W), .SETTLE(S)) dut (
        .clk150kHz(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
        .clear_overrun(clear_overrun), .y_filtro(y_filtro), .uk(uk), .sel_muxes(sel_muxes),
        .enable1(enable1), .enable2(enable2), .enable3(enable3), .y_altas(y_altas),
        .y_medias(y_medias), .y_bajas(y_bajas), .bands_valid(bands_valid), .busy(busy),
        .overrun(overrun), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Filter model: one fixed output per band select.
    always_comb begin
        case (sel_muxes)
            2'd0:    y_filtro = y_tab[0];
            2'd1:    y_filtro = y_tab[1];
            2'd2:    y_filtro = y_tab[2];
            default: y_filtro = '0;
        endcase
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (bands_valid === 1'b1) begin
            bv_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_bands_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_y_altas", y_altas, mon_e[3*W-1 -: W]);
                chk("sb_y_medias", y_medias, mon_e[2*W-1 -: W]);
                chk("sb_y_bajas", y_bajas, mon_e[W-1 -: W]);
            end
        end
    end

    task automatic step_inputs();
        exp_ovr       = drv_drop ? 1'b1 : (drv_clr ? 1'b0 : exp_ovr);
        drv_drop      = 1'b0;
        drv_clr       = 1'b0;
        sample_valid  = 1'b0;
        clear_overrun = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_uk"}, uk, '0);
        chk({tag, "_sel"}, W'(sel_muxes), '0);
        chk({tag, "_enables"}, W'({enable1, enable2, enable3}), '0);
        chk({tag, "_y_altas"}, y_altas, '0);
        chk({tag, "_y_medias"}, y_medias, '0);
        chk({tag, "_y_bajas"}, y_bajas, '0);
        chk({tag, "_flags"}, W'({bands_valid, busy, overrun}), '0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            step_inputs();
            chk("idle_busy", W'(busy), '0);
            chk("idle_enables", W'({enable1, enable2, enable3}), '0);
            chk("idle_bands_valid", W'(bands_valid), '0);
            chk("idle_sel", W'(sel_muxes), '0);
            chk("idle_overrun", W'(overrun), W'(exp_ovr));
        end
    endtask

    // Called at a negedge in an idle cycle; returns at the negedge of the first idle cycle after DONE.
    task automatic run_seq(input logic signed [W-1:0] s, input logic signed [W-1:0] ya,
                           input logic signed [W-1:0] ym, input logic signed [W-1:0] yb,
                           input int drop_cyc, input logic clr_drop);
        int   nb;
        logic cap;
        y_tab[0] = ya;
        y_tab[1] = ym;
        y_tab[2] = yb;
        exp_q.push_back({ya, ym, yb});
        sample_valid = 1'b1;
        sample_in    = s;
        for (int c = 0; c <= LAST + 1; c++) begin
            @(negedge clk);
            step_inputs();
            if (c <= LAST) begin
                nb  = (c < LAST) ? c / (S + 1) : 2;
                cap = (c < LAST) && ((c % (S + 1)) == S);
                chk("sel_muxes", W'(sel_muxes), W'(nb));
                chk("enable1", W'(enable1), W'(cap && nb == 0));
                chk("enable2", W'(enable2), W'(cap && nb == 1));
                chk("enable3", W'(enable3), W'(cap && nb == 2));
                chk("bands_valid", W'(bands_valid), W'(c == LAST));
                chk("busy", W'(busy), W'(1));
            end else begin
                chk("end_busy", W'(busy), '0);
                chk("end_sel", W'(sel_muxes), '0);
                chk("end_enables", W'({enable1, enable2, enable3, bands_valid}), '0);
            end
            chk("uk", uk, s);
            chk("overrun", W'(overrun), W'(exp_ovr));
            if (c == drop_cyc) begin
                sample_valid  = 1'b1;
                sample_in     = 777;
                clear_overrun = clr_drop;
                drv_drop      = 1'b1;
                drv_clr       = clr_drop;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        sample_valid = 1'b0;
        sample_in = '0;
        clear_overrun = 1'b0;
        y_tab[0] = '0;
        y_tab[1] = '0;
        y_tab[2] = '0;
        exp_ovr = 1'b0;
        drv_drop = 1'b0;
        drv_clr = 1'b0;

        // Reset then idle.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        idle_cycles(10);
        check_all_zero("post_idle");

        // Single sample with a dropped second sample in cycle 4.
        run_seq(16384, 1000, 2000, 3000, 4, 1'b0);
        idle_cycles(2);
        chk("hold_y_altas", y_altas, W'(1000));
        chk("hold_y_bajas", y_bajas, W'(3000));

        // Negative data; clear coinciding with a drop leaves overrun set.
        run_seq(-8192, -500, -1, -2097152, 3, 1'b1);
        chk("overrun_set_wins", W'(overrun), W'(1));
        clear_overrun = 1'b1;
        drv_clr = 1'b1;
        idle_cycles(2);
        chk("overrun_cleared", W'(overrun), '0);

        // Back-to-back samples at the first idle cycle.
        run_seq(100, 11, 22, 33, -1, 1'b0);
        run_seq(200, 44, 55, 66, -1, 1'b0);
        chk("bv_spacing", W'(bv_cyc[bv_cyc.size()-1] - bv_cyc[bv_cyc.size()-2]), W'(LAST + 2));

        // Reset in cycle 6 of a sequence aborts it.
        y_tab[0] = 5;
        y_tab[1] = 6;
        y_tab[2] = 7;
        sample_valid = 1'b1;
        sample_in = 4242;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            step_inputs();
            chk("abort_busy", W'(busy), W'(1));
        end
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_ovr = 1'b0;
        idle_cycles(12);
        check_all_zero("after_abort");
        run_seq(1234, 9, 8, 7, -1, 1'b0);

        idle_cycles(3);
        chk("queue_empty", W'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
